// File: rtl/song_pkg.sv
// Shared types and defaults for the song player: FSM states, bus widths, rest code.
// Latency: none. Backpressure: none.
package song_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP,
        DONE
    } player_state_t;

    localparam int SONG_ADDR_W = 5;
    localparam int SONG_NOTE_W = 16;
    localparam int NOTE_REST   = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/song_player_tone_gen.sv
// Half-period divider: toggles tone every half_period cycles while en is high.
// Latency: first toggle half_period cycles after en rises. Backpressure: none; en=0 clears and silences.
module tone_gen
    import song_pkg::*;
#(
    parameter int NOTE_W = SONG_NOTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NOTE_W-1:0] half_period,
    output logic              tone
);

    logic [NOTE_W-1:0] half_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            tone     <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            tone     <= 1'b0;
        end else if (half_cnt == half_period - NOTE_W'(1)) begin
            half_cnt <= '0;
            tone     <= ~tone;
        end else begin
            half_cnt <= half_cnt + NOTE_W'(1);
        end
    end

endmodule

// File: rtl/song_player.sv
// Steps a 1-cycle-latency song ROM, sounds each note for NOTE_TICKS then GAP_TICKS of silence.
// Latency: start -> first tone edge = 2 + note cycles. Backpressure: none; stop aborts at once.
// Build option SONG_PLAYER_LOOP_EN: end of song restarts from address 0 instead of entering DONE.
module song_player
    import song_pkg::*;
#(
    parameter int ADDR_W     = SONG_ADDR_W,
    parameter int NOTE_W     = SONG_NOTE_W,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 1_250_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    output logic              tone,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max_int(NOTE_TICKS, GAP_TICKS) + 1);
    localparam logic [CNT_W-1:0]  NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    player_state_t     state;
    logic [CNT_W-1:0]  dur_cnt;
    logic [NOTE_W-1:0] note_q;
    logic              tone_en;

    // Drop enable on the last PLAY cycle (or on stop) so tone is already low
    // in the first GAP/IDLE cycle.
    assign tone_en = (state == PLAY) && (dur_cnt != NOTE_LAST) && !stop;

    tone_gen #(
        .NOTE_W(NOTE_W)
    ) u_tone_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (tone_en),
        .half_period(note_q),
        .tone       (tone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            dur_cnt  <= '0;
            note_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (stop) begin
            state    <= IDLE;
            rom_addr <= '0;
            dur_cnt  <= '0;
            note_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rom_addr <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    dur_cnt <= '0;
                    if (rom_note == NOTE_W'(NOTE_REST)) begin
`ifdef SONG_PLAYER_LOOP_EN
                        if (rom_addr == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rom_addr <= '0;
                            state    <= FETCH;
                        end
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        note_q <= rom_note;
                        state  <= PLAY;
                    end
                end
                PLAY: begin
                    if (dur_cnt == NOTE_LAST) begin
                        dur_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        dur_cnt <= dur_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (dur_cnt == GAP_LAST) begin
                        dur_cnt  <= '0;
                        rom_addr <= rom_addr + ADDR_W'(1);
`ifdef SONG_PLAYER_LOOP_EN
                        state    <= FETCH;
`else
                        // Stepping past the last address ends the song; no replay.
                        if (rom_addr == ADDR_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
`endif
                    end else begin
                        dur_cnt <= dur_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_player.sv
// Bench for song_player with NOTE_TICKS=20, GAP_TICKS=4 and a 1-cycle behavioural ROM.
module tb_song_player;

    localparam int NT = 20;
    localparam int GT = 4;

    typedef struct packed {
        logic       tone;
        logic       busy;
        logic       done;
        logic [4:0] addr;
    } obs_t;

    typedef struct {
        int note;
        int first_edge;
        int toggles;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [4:0]  rom_addr;
    logic [15:0] rom_note;
    logic        tone;
    logic        busy;
    logic        done;

    logic [15:0] rom [32];
    obs_t        exp_q[$];
    int          checks;
    int          failures;

    song_player #(
        .ADDR_W    (5),
        .NOTE_W    (16),
        .NOTE_TICKS(NT),
        .GAP_TICKS (GT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .rom_addr(rom_addr),
        .rom_note(rom_note),
        .tone    (tone),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_note <= rom[rom_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.tone = tone;
        o.busy = busy;
        o.done = done;
        o.addr = rom_addr;
        return o;
    endfunction

    function automatic obs_t mk(input logic t, input logic b, input logic d, input int a);
        obs_t o;
        o.tone = t;
        o.busy = b;
        o.done = d;
        o.addr = a[4:0];
        return o;
    endfunction

    task automatic check_int(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, expv);
        end
    endtask

    task automatic check_obs(input string name, input int idx, input obs_t expv, output bit ok);
        obs_t got;
        got = sample();
        checks++;
        ok = (got === expv);
        if (!ok) begin
            failures++;
            $display("FAIL %s cycle %0d: got tone=%b busy=%b done=%b addr=%0d required tone=%b busy=%b done=%b addr=%0d",
                     name, idx, got.tone, got.busy, got.done, got.addr,
                     expv.tone, expv.busy, expv.done, expv.addr);
        end
    endtask

    // Expected per-cycle outputs, entry i = values after the i-th clock edge from the start edge.
    task automatic build_model(input int max_len);
        int  addr;
        int  n;
        bit  fin;
        exp_q.delete();
        addr = 0;
        fin  = 0;
        while (!fin && exp_q.size() < max_len) begin
            exp_q.push_back(mk(0, 1, 0, addr));
            exp_q.push_back(mk(0, 1, 0, addr));
            n = int'(rom[addr]);
            if (n == 0) begin
`ifdef SONG_PLAYER_LOOP_EN
                if (addr == 0) begin
                    for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 0, 0));
                    fin = 1;
                end else begin
                    addr = 0;
                end
`else
                for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 1, addr));
                fin = 1;
`endif
            end else begin
                for (int c = 0; c < NT; c++) exp_q.push_back(mk(logic'((c / n) % 2), 1, 0, addr));
                for (int c = 0; c < GT; c++) exp_q.push_back(mk(0, 1, 0, addr));
                if (addr == 31) begin
`ifdef SONG_PLAYER_LOOP_EN
                    addr = 0;
`else
                    for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 1, 0));
                    fin = 1;
`endif
                end else begin
                    addr++;
                end
            end
        end
        while (exp_q.size() > max_len) void'(exp_q.pop_back());
    endtask

    // Called at a negedge: pulses start, then compares every cycle against exp_q.
    task automatic run_check(input string name, input int stop_at, input int start_at);
        obs_t expv;
        bit   ok;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            expv = (stop_at >= 0 && i > stop_at) ? mk(0, 0, 0, 0) : exp_q[i];
            check_obs(name, i, expv, ok);
            if (!ok) break;
            start = (i == start_at);
            stop  = (i == stop_at);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        bit   ok;
        int   prev;
        int   first;
        int   tog;
        int   len;
        int   waited;
        int   sa;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        stop     = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 16'd0;

        vecs[0] = '{1,     3,  19};
        vecs[1] = '{2,     4,  9};
        vecs[2] = '{3,     5,  6};
        vecs[3] = '{5,     7,  3};
        vecs[4] = '{7,     9,  2};
        vecs[5] = '{19,    21, 1};
        vecs[6] = '{20,    -1, 0};
        vecs[7] = '{40000, -1, 0};

        repeat (3) @(negedge clk);
        check_obs("reset_state", 0, mk(0, 0, 0, 0), ok);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_obs("idle_after_reset", 0, mk(0, 0, 0, 0), ok);

        // Single-note songs: first tone edge latency and toggle count within one note.
        foreach (vecs[v]) begin
            rom[0] = vecs[v].note[15:0];
            rom[1] = 16'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            prev  = 0;
            first = -1;
            tog   = 0;
            for (int k = 0; k <= NT + 1; k++) begin
                if (k >= 1 && int'(tone) != prev) begin
                    tog++;
                    if (first < 0) first = k;
                end
                prev = int'(tone);
                @(negedge clk);
            end
            check_int($sformatf("first_edge_note%0d", vecs[v].note), first, vecs[v].first_edge);
            check_int($sformatf("toggles_note%0d", vecs[v].note), tog, vecs[v].toggles);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end

        rom[0] = 16'd3;
        rom[1] = 16'd5;
        rom[2] = 16'd0;
        build_model(170);
        run_check("song_3_5_0", -1, -1);

        build_model(170);
        run_check("stop_mid_note1", 35, -1);
        build_model(170);
        run_check("replay_after_stop", -1, -1);

        build_model(170);
        run_check("start_during_play", -1, 10);

        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_obs("start_stop_same_cycle", 0, mk(0, 0, 0, 0), ok);
        repeat (3) @(negedge clk);
        check_obs("start_stop_still_idle", 3, mk(0, 0, 0, 0), ok);

        for (int i = 0; i < 32; i++) rom[i] = 16'd2;
        build_model(32 * (2 + NT + GT) + 6);
        run_check("all32_no_terminator", -1, -1);

        // Async reset while tone is high.
        rom[0] = 16'd3;
        rom[1] = 16'd5;
        rom[2] = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (tone !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_int("tone_high_before_reset", int'(tone), 1);
        #1 rst_n = 1'b0;
        #1;
        check_obs("async_reset_mid_note", 0, mk(0, 0, 0, 0), ok);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_obs("idle_after_reset_release", 8, mk(0, 0, 0, 0), ok);
        build_model(170);
        run_check("replay_after_reset", -1, -1);

        // Randomized songs, some aborted at a random cycle.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < 32; i++) rom[i] = 16'($urandom_range(1, 9));
            rom[len] = 16'd0;
            build_model(200);
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1;
            run_check($sformatf("random_song%0d", r), sa, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
